// File: rtl/mult_div_unit.sv
// Sequential 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO; divider built only with MULT_DIV_DIVIDER_EN.
// Latency: 34 cycles start-to-start (done one cycle after FIX); divide-by-zero or no-divider DIV finishes in 2.
// Backpressure: busy stalls the control path; start/mthi/mtlo are ignored while busy.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        mthi,
   input  logic        mtlo,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [63:0] acc;
   logic [31:0] addend;
   logic        neg_res;
   logic        skip_wr;

   logic        op_signed;
   logic [31:0] abs_rs;
   logic [31:0] abs_rt;
   logic        skip_now;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [63:0] prod_fix;

   assign op_signed = ~op[0];
   assign abs_rs    = (op_signed && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
   assign abs_rt    = (op_signed && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each cycle.
   assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, addend} : 33'd0);
   assign mul_next = {mul_sum, acc[31:1]};
   assign prod_fix = neg_res ? (~acc + 64'd1) : acc;

`ifdef MULT_DIV_DIVIDER_EN
   logic        is_div;
   logic        neg_rem;
   logic [32:0] rem_sh;
   logic [33:0] div_diff;
   logic        div_ge;
   logic [63:0] div_next;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign skip_now = op[1] && (rt_data == 32'd0);

   // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
   assign rem_sh   = acc[63:31];
   assign div_diff = {1'b0, rem_sh} - {2'b00, addend};
   assign div_ge   = ~div_diff[33];
   assign div_next = {(div_ge ? div_diff[31:0] : rem_sh[31:0]), acc[30:0], div_ge};
   assign quo_fix  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
   assign rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
`else
   assign skip_now = op[1];
`endif

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= 6'd0;
         acc         <= 64'd0;
         addend      <= 32'd0;
         neg_res     <= 1'b0;
         skip_wr     <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= 32'd0;
         lo          <= 32'd0;
`ifdef MULT_DIV_DIVIDER_EN
         is_div      <= 1'b0;
         neg_rem     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cnt         <= 6'd0;
                  skip_wr     <= skip_now;
                  div_by_zero <= 1'b0;
                  neg_res     <= op_signed && (rs_data[31] ^ rt_data[31]);
`ifdef MULT_DIV_DIVIDER_EN
                  is_div      <= op[1];
                  neg_rem     <= op_signed && rs_data[31];
                  addend      <= op[1] ? abs_rt : abs_rs;
                  acc         <= {32'd0, (op[1] ? abs_rs : abs_rt)};
`else
                  addend      <= abs_rs;
                  acc         <= {32'd0, abs_rt};
`endif
                  state       <= skip_now ? ST_FIX : ST_CALC;
               end else begin
                  if (mthi) hi <= rs_data;
                  if (mtlo) lo <= rs_data;
               end
            end
            ST_CALC: begin
`ifdef MULT_DIV_DIVIDER_EN
               acc <= is_div ? div_next : mul_next;
`else
               acc <= mul_next;
`endif
               if (cnt == 6'd31) state <= ST_FIX;
               else              cnt   <= cnt + 6'd1;
            end
            ST_FIX: begin
               done  <= 1'b1;
               state <= ST_IDLE;
`ifdef MULT_DIV_DIVIDER_EN
               div_by_zero <= skip_wr;
               if (!skip_wr) begin
                  if (is_div) begin
                     lo <= quo_fix;
                     hi <= rem_fix;
                  end else begin
                     hi <= prod_fix[63:32];
                     lo <= prod_fix[31:0];
                  end
               end
`else
               if (!skip_wr) begin
                  hi <= prod_fix[63:32];
                  lo <= prod_fix[31:0];
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO, handshake timing, ignored requests and reset abort.
module tb_mult_div_unit;

`ifdef MULT_DIV_DIVIDER_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs_data = 32'd0;
   logic [31:0] rt_data = 32'd0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   int busy_cnt, done_cnt, done_at, hold_err;
   logic dbz_at1;
   logic rst_busy, rst_done, rst_dbz;
   logic [31:0] rst_hi, rst_lo;

   mult_div_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issues one start and watches 40 cycles; optional injected request / reset at given cycle.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, input int rst_at);
      logic [31:0] hi0, lo0;
      @(negedge clk);
      op = o; rs_data = a; rt_data = b; start = 1'b1;
      hi0 = hi; lo0 = lo;
      busy_cnt = 0; done_cnt = 0; done_at = 0; hold_err = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) dbz_at1 = div_by_zero;
         if (busy) begin
            busy_cnt++;
            if (hi !== hi0 || lo !== lo0) hold_err++;
         end
         if (done) begin
            done_cnt++;
            if (done_at == 0) done_at = i;
         end
         if (i == rst_at + 1) begin
            rst_busy = busy; rst_done = done; rst_dbz = div_by_zero;
            rst_hi = hi; rst_lo = lo;
            reset = 1'b0;
         end
         start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
         if (i == inj_at) begin
            start = 1'b1; op = 2'b10; mthi = 1'b1; rs_data = 32'hDEAD; rt_data = 32'd0;
         end
         if (i == rst_at) reset = 1'b1;
      end
   endtask

   task automatic mt_write(input logic h, input logic l, input logic [31:0] v);
      @(negedge clk);
      mthi = h; mtlo = l; rs_data = v;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_dbz", div_by_zero, 1'b0);
      check("rst_hilo", {hi, lo}, 64'd0);
      reset = 1'b0;

      // MULT -3 * 7 = -21
      do_op(2'b00, 32'hFFFFFFFD, 32'd7, -5, -5);
      check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
      check("mult_done_at", done_at, 34);
      check("mult_busy_cycles", busy_cnt, 33);
      check("mult_done_pulses", done_cnt, 1);
      check("mult_hold", hold_err, 0);

      do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -5, -5);
      check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
      do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, -5, -5);
      check("mult_m1_m1", {hi, lo}, 64'h00000000_00000001);

      // DIV -7 / 2 = -3 rem -1; without the divider HI/LO keep 0/1
      do_op(2'b10, 32'hFFFFFFF9, 32'd2, -5, -5);
      check("div_neg_hilo", {hi, lo}, DIV_EN ? 64'hFFFFFFFF_FFFFFFFD : 64'h00000000_00000001);
      check("div_neg_done_at", done_at, DIV_EN ? 34 : 2);
      check("div_neg_busy", busy_cnt, DIV_EN ? 33 : 1);

      do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -5, -5);
      check("div_ovf_hilo", {hi, lo}, DIV_EN ? 64'h00000000_80000000 : 64'h00000000_00000001);
      check("div_ovf_dbz", div_by_zero, 1'b0);

      mt_write(1'b1, 1'b1, 32'h55);
      check("mt_both", {hi, lo}, 64'h00000055_00000055);
      mt_write(1'b1, 1'b0, 32'h11);
      check("mthi_only", {hi, lo}, 64'h00000011_00000055);
      mt_write(1'b0, 1'b1, 32'h22);
      check("mtlo_only", {hi, lo}, 64'h00000011_00000022);

      do_op(2'b11, 32'd100, 32'd0, -5, -5);
      check("dz_done_at", done_at, 2);
      check("dz_busy", busy_cnt, 1);
      check("dz_flag", div_by_zero, DIV_EN);
      check("dz_hilo", {hi, lo}, 64'h00000011_00000022);

      do_op(2'b01, 32'd3, 32'd4, -5, -5);
      check("dz_clear_at_accept", dbz_at1, 1'b0);
      check("multu_3x4", {hi, lo}, 64'd12);

      // Ignored start (DIV by 0) and mthi mid-operation; operands change too
      do_op(2'b01, 32'd5, 32'd6, 10, -5);
      check("ign_hilo", {hi, lo}, 64'd30);
      check("ign_done_pulses", done_cnt, 1);
      check("ign_done_at", done_at, 34);
      check("ign_hold", hold_err, 0);
      check("ign_dbz", div_by_zero, 1'b0);

      // Reset mid-CALC aborts
      do_op(2'b01, 32'd7, 32'd9, -5, 15);
      check("abort_busy", rst_busy, 1'b0);
      check("abort_done", rst_done, 1'b0);
      check("abort_dbz", rst_dbz, 1'b0);
      check("abort_hilo", {rst_hi, rst_lo}, 64'd0);
      check("abort_no_done", done_cnt, 0);
      check("abort_after_hilo", {hi, lo}, 64'd0);

      // Unit recovers after abort
      do_op(2'b00, 32'd6, 32'hFFFFFFFE, -5, -5);
      check("post_reset_mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFF4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential 32-bit multiply/divide unit that sits directly downstream of the register file. It consumes the two register read operands (rs/rt) for MULT/MULTU/DIV/DIVU and produces results in dedicated HI/LO registers after a fixed multi-cycle latency. It signals completion with a busy/done handshake that the control path uses to stall. The unit also services MTHI/MTLO writes from the register file's read port.

## Interface
- No parameters; the datapath width is fixed at 32 bits.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  request to begin the operation on `op`; sampled only when idle.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  32  multiplicand or dividend (register file read_data1).
- rt_data  input  32  multiplier or divisor (register file read_data2).
- mthi  input  1  write rs_data into HI; honoured only when idle.
- mtlo  input  1  write rs_data into LO; honoured only when idle.
- busy  output  1  an operation is in progress; reset 0.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation; reset 0.
- div_by_zero  output  1  the last DIV/DIVU had rt_data = 0; sticky until the next accepted start; reset 0.
- hi  output  32  HI register; reset 0.
- lo  output  32  LO register; reset 0.

## Operation
- States:
  - IDLE: waits for start.
  - CALC: 32 radix-2 iterations.
  - FIX: sign correction and HI/LO write.
- Accept:
  - In IDLE with start=1, the unit latches op, |rs|, |rt| (absolute value for signed ops, raw value for unsigned) and the result signs.
  - It clears div_by_zero, loads iteration counter = 0 and moves to CALC.
- Multiply:
  - Shift-add into a 64-bit accumulator, 1 bit per cycle.
  - In FIX, the 64-bit product is negated if the operand signs differ (signed op only).
  - HI receives product[63:32] and LO receives product[31:0].
- Divide:
  - Restoring shift-subtract, 1 quotient bit per cycle.
  - In FIX, the quotient is negated if the signs differ, and the remainder takes the sign of the dividend.
  - LO receives the quotient and HI receives the remainder.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000 and HI=0x00000000 (wraps, no flag).
- Divide by zero:
  - Detected at accept. The unit goes IDLE → FIX directly with no CALC.
  - div_by_zero=1, HI/LO unchanged, done pulses.
- MTHI/MTLO: in IDLE, with start=0, the write takes effect on the next edge. Both may be asserted together.
- Ignored requests:
  - start, mthi and mtlo are ignored while busy.
  - In IDLE, start has priority over mthi/mtlo in the same cycle, and the mthi/mtlo request is dropped.
- All arithmetic is modulo its stated width. The counter is 6 bits and leaves CALC when it reaches 31 on the 32nd iteration edge.

## Timing
- Let edge N be the edge that accepts start.
- busy goes 1 after edge N.
- CALC occupies edges N+1..N+32, and FIX occurs at edge N+33.
- After edge N+33: HI/LO hold the results, done=1 for exactly one cycle, and busy=0.
- A new start may be accepted at edge N+34; back-to-back throughput is one operation per 34 cycles.
- Divide by zero: FIX at edge N+1, done high during the following cycle, busy high for exactly one cycle.
- HI/LO are stable throughout CALC; they change only at FIX, on an MTHI/MTLO edge, or on reset.
- Reset asserted at any edge (including mid-CALC) aborts the operation. Next cycle: state IDLE, busy=0, done=0, div_by_zero=0, hi=lo=0, and no done pulse is emitted for the aborted operation.
- Operands are sampled only at edge N; changes on rs_data/rt_data during busy have no effect.

## Configuration
- MULT_DIV_DIVIDER_EN
  - Defined: the divider datapath is compiled in and DIV/DIVU behave as specified above.
  - Undefined: no divider logic. op 10/11 with start are accepted and complete via FIX at edge N+1 (same timing as divide by zero), with HI/LO unchanged and div_by_zero=0.
  - Multiply and MTHI/MTLO are identical in both builds.

## Test plan
- MULT rs=0xFFFFFFFD (-3), rt=7 → done one cycle after edge N+33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU rs=rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Then MULT with the same operands → HI=0x00000000, LO=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU rs=100, rt=0, with HI=0x11, LO=0x22 preloaded via mthi/mtlo → done after one busy cycle, div_by_zero=1, HI=0x11, LO=0x22. A following MULTU 3*4 → div_by_zero clears at accept; LO=12, HI=0.
- Ignored requests and reset:
  - MULTU 5*6 with start re-pulsed (op DIV) and mthi pulsed at cycle 10 → both ignored; result LO=30, HI=0, only one done pulse.
  - A second MULTU with reset asserted at cycle 15 → busy=0, hi=lo=0 next cycle, and no done pulse follows.
